uart_auth_ctrl: RTL and testbench

UART_AUTH_CTRL -- requirements
Module: uart_auth_ctrl

---
 rtl/uart_auth_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_uart_auth_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_auth_ctrl.sv
// UART-commanded power authorisation controller.
// 8N1 receiver, rider-off debounce and OFF/ON/STOP_PEND power FSM.
module uart_auth_ctrl #(
  parameter int BAUD_DIV  = 2604,
  parameter logic [7:0] GO_CODE   = 8'h67,
  parameter logic [7:0] STOP_CODE = 8'h73,
  parameter int TMO_CYC   = 50_000_000,
  parameter int DBNC_CYC  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [1:0] auth_state,
  output logic       rx_err,
  output logic       tmo
);

  localparam int CW = $clog2(BAUD_DIV + BAUD_DIV / 2 + 1);
  localparam int DW = $clog2(DBNC_CYC + 1);
  localparam int TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

  localparam logic [CW-1:0] FIRST_CNT = CW'(BAUD_DIV + BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_CNT   = CW'(BAUD_DIV - 1);
  localparam logic [DW-1:0] DBNC_MAX  = DW'(DBNC_CYC);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_DATA = 2'b01,
    R_STOP = 2'b10
  } rx_st_t;

  typedef enum logic [1:0] {
    S_OFF = 2'b00,
    S_ON  = 2'b01,
    S_SP  = 2'b10
  } auth_st_t;

  logic          rx_s1, rx_s2;
  rx_st_t        rx_st, rx_st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          armed, armed_n;
  logic          byte_vld, byte_vld_n;
  logic          err_n;

  logic [DW-1:0] dbnc;
  logic          rider_off_db;

  auth_st_t      state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic          tmo_n;
  logic          is_go, is_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_st    <= R_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      armed    <= 1'b0;
      byte_vld <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_s1    <= RX;
      rx_s2    <= rx_s1;
      rx_st    <= rx_st_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      armed    <= armed_n;
      byte_vld <= byte_vld_n;
      rx_err   <= err_n;
    end
  end

  // A held-low line after a framing error must not restart the receiver
  always_comb begin
    rx_st_n    = rx_st;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    armed_n    = armed | rx_s2;
    byte_vld_n = 1'b0;
    err_n      = 1'b0;
    case (rx_st)
      R_IDLE: begin
        if (armed && !rx_s2) begin
          rx_st_n   = R_DATA;
          cnt_n     = FIRST_CNT;
          bit_cnt_n = '0;
        end
      end
      R_DATA: begin
        if (cnt == '0) begin
          shreg_n   = {rx_s2, shreg[7:1]};
          cnt_n     = BIT_CNT;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx_st_n = R_STOP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      R_STOP: begin
        if (cnt == '0) begin
          rx_st_n = R_IDLE;
          if (rx_s2) begin
            byte_vld_n = 1'b1;
          end else begin
            err_n   = 1'b1;
            armed_n = 1'b0;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: rx_st_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbnc <= '0;
    end else if (!rider_off) begin
      dbnc <= '0;
    end else if (dbnc != DBNC_MAX) begin
      dbnc <= dbnc + DW'(1);
    end
  end

  assign rider_off_db = (dbnc == DBNC_MAX);
  assign is_go        = byte_vld && (shreg == GO_CODE);
  assign is_stop      = byte_vld && (shreg == STOP_CODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OFF;
      tmr   <= '0;
      tmo   <= 1'b0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      tmo   <= tmo_n;
    end
  end

  always_comb begin
    state_n = state;
    tmo_n   = 1'b0;
    case (state)
      S_OFF: if (is_go) state_n = S_ON;
      S_ON: begin
        if (is_stop) state_n = rider_off_db ? S_OFF : S_SP;
      end
      S_SP: begin
        if (rider_off_db) begin
          state_n = S_OFF;
        end else if (is_go) begin
          state_n = S_ON;
        end else if (tmr == TMO_LAST) begin
          state_n = S_OFF;
          tmo_n   = 1'b1;
        end
      end
      default: state_n = S_OFF;
    endcase
  end

  // Timer restarts on each entry into STOP_PEND
  always_comb begin
    tmr_n = '0;
    if (state == S_SP && state_n == S_SP) tmr_n = tmr + TW'(1);
  end

  assign auth_state = state;
  assign pwr_up     = (state == S_ON) || (state == S_SP);

endmodule

// File: tb/tb_uart_auth_ctrl.sv
// Bench for uart_auth_ctrl: directed scenarios plus random byte streams
// checked against a byte-level model of the authorisation rules.
module tb_uart_auth_ctrl;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       rider_off;
  logic       pwr_up, rx_err, tmo;
  logic [1:0] auth_state;
  logic       pwr_up_l, rx_err_l, tmo_l;
  logic [1:0] auth_l;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tmo_cnt, err_cnt, tmo_cnt_l, err_cnt_l;
  int rise_cyc, sp_cyc, off_cyc, sp_cyc_l, off_cyc_l, frame_cyc;
  logic       pwr_q = 1'b0;
  logic [1:0] auth_q = 2'b00;
  logic [1:0] auth_lq = 2'b00;

  uart_auth_ctrl #(
    .BAUD_DIV(BD), .GO_CODE(8'h67), .STOP_CODE(8'h73),
    .TMO_CYC(100), .DBNC_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .RX(RX), .rider_off(rider_off),
    .pwr_up(pwr_up), .auth_state(auth_state),
    .rx_err(rx_err), .tmo(tmo)
  );

  // Longer timeout so a GO frame can land inside the STOP_PEND window
  uart_auth_ctrl #(
    .BAUD_DIV(BD), .GO_CODE(8'h67), .STOP_CODE(8'h73),
    .TMO_CYC(400), .DBNC_CYC(4)
  ) dut_l (
    .clk(clk), .rst(rst), .RX(RX), .rider_off(rider_off),
    .pwr_up(pwr_up_l), .auth_state(auth_l),
    .rx_err(rx_err_l), .tmo(tmo_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tmo) tmo_cnt++;
    if (rx_err) err_cnt++;
    if (tmo_l) tmo_cnt_l++;
    if (rx_err_l) err_cnt_l++;
    if (pwr_up && !pwr_q) rise_cyc = cyc;
    pwr_q = pwr_up;
    if (auth_state != auth_q) begin
      if (auth_state == 2'b10) sp_cyc = cyc;
      if (auth_state == 2'b00) off_cyc = cyc;
    end
    auth_q = auth_state;
    if (auth_l != auth_lq) begin
      if (auth_l == 2'b10) sp_cyc_l = cyc;
      if (auth_l == 2'b00) off_cyc_l = cyc;
    end
    auth_lq = auth_l;
  end

  function automatic logic [1:0] model(input logic [1:0] s,
                                       input logic [7:0] b);
    if (s == 2'b00 && b == 8'h67) return 2'b01;
    if (s == 2'b01 && b == 8'h73) return 2'b10;
    return s;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input int gap);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(posedge clk);
    #1;
    frame_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      cycles(BD);
    end
    RX = 1'b1;
    cycles(gap);
  endtask

  task automatic clr_cnt();
    tmo_cnt = 0;
    err_cnt = 0;
    tmo_cnt_l = 0;
    err_cnt_l = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    RX = 1'b1;
    rider_off = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(4);
    clr_cnt();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    RX = 1'b1;
    rider_off = 1'b0;
    #1;
    total++;
    if (pwr_up !== 1'b0) begin
      bad++; $display("FAIL rst_pwr_up got=%b exp=0", pwr_up);
    end
    total++;
    if (auth_state !== 2'b00) begin
      bad++; $display("FAIL rst_auth got=%b exp=00", auth_state);
    end
    total++;
    if (rx_err !== 1'b0) begin
      bad++; $display("FAIL rst_rx_err got=%b exp=0", rx_err);
    end
    total++;
    if (tmo !== 1'b0) begin
      bad++; $display("FAIL rst_tmo got=%b exp=0", tmo);
    end
    cycles(3);
    rst = 1'b0;
    cycles(4);
    clr_cnt();
    total++;
    if (auth_state !== 2'b00) begin
      bad++; $display("FAIL post_rst_auth got=%b exp=00", auth_state);
    end
  endtask

  task automatic test_go_ignore();
    int lat;
    send_byte(8'h41, 1'b1, 4);
    total++;
    if (auth_state !== 2'b00) begin
      bad++; $display("FAIL ignore_41 got=%b exp=00", auth_state);
    end
    rise_cyc = -1;
    send_byte(8'h67, 1'b1, 4);
    total++;
    if (auth_state !== 2'b01) begin
      bad++; $display("FAIL go_auth got=%b exp=01", auth_state);
    end
    total++;
    if (pwr_up !== 1'b1) begin
      bad++; $display("FAIL go_pwr_up got=%b exp=1", pwr_up);
    end
    lat = rise_cyc - frame_cyc;
    total++;
    if (lat < 150 || lat > 160) begin
      bad++; $display("FAIL go_latency got=%0d exp=150..160", lat);
    end
  endtask

  task automatic test_timeout();
    tmo_cnt = 0;
    send_byte(8'h73, 1'b1, 2);
    total++;
    if (auth_state !== 2'b10) begin
      bad++; $display("FAIL stop_pend got=%b exp=10", auth_state);
    end
    total++;
    if (pwr_up !== 1'b1) begin
      bad++; $display("FAIL stop_pend_pwr got=%b exp=1", pwr_up);
    end
    for (int i = 0; i < 200 && auth_state !== 2'b00; i++) cycles(1);
    cycles(5);
    total++;
    if (auth_state !== 2'b00) begin
      bad++; $display("FAIL tmo_off got=%b exp=00", auth_state);
    end
    total++;
    if (tmo_cnt !== 1) begin
      bad++; $display("FAIL tmo_pulses got=%0d exp=1", tmo_cnt);
    end
    total++;
    if (pwr_up !== 1'b0) begin
      bad++; $display("FAIL tmo_pwr got=%b exp=0", pwr_up);
    end
    total++;
    if (off_cyc - sp_cyc !== 100) begin
      bad++; $display("FAIL tmo_len got=%0d exp=100", off_cyc - sp_cyc);
    end
  endtask

  task automatic test_rider();
    do_reset();
    send_byte(8'h67, 1'b1, 2);
    rider_off = 1'b1;
    cycles(10);
    total++;
    if (auth_state !== 2'b01) begin
      bad++; $display("FAIL on_holds_rider got=%b exp=01", auth_state);
    end
    send_byte(8'h73, 1'b1, 4);
    total++;
    if (auth_state !== 2'b00) begin
      bad++; $display("FAIL stop_rider_off got=%b exp=00", auth_state);
    end
    rider_off = 1'b0;
    cycles(2);
    send_byte(8'h67, 1'b1, 2);
    send_byte(8'h73, 1'b1, 2);
    rider_off = 1'b1;
    cycles(3);
    rider_off = 1'b0;
    cycles(5);
    total++;
    if (auth_state !== 2'b10) begin
      bad++; $display("FAIL rider_3cyc got=%b exp=10", auth_state);
    end
    rider_off = 1'b1;
    cycles(4);
    rider_off = 1'b0;
    cycles(3);
    total++;
    if (auth_state !== 2'b00) begin
      bad++; $display("FAIL rider_4cyc got=%b exp=00", auth_state);
    end
    cycles(120);
    total++;
    if (tmo_cnt !== 0) begin
      bad++; $display("FAIL rider_no_tmo got=%0d exp=0", tmo_cnt);
    end
  endtask

  task automatic test_resume();
    do_reset();
    send_byte(8'h67, 1'b1, 4);
    send_byte(8'h73, 1'b1, 4);
    total++;
    if (auth_l !== 2'b10) begin
      bad++; $display("FAIL resume_sp got=%b exp=10", auth_l);
    end
    send_byte(8'h67, 1'b1, 4);
    total++;
    if (auth_l !== 2'b01 || pwr_up_l !== 1'b1) begin
      bad++;
      $display("FAIL resume_on got=%b/%b exp=01/1", auth_l, pwr_up_l);
    end
    send_byte(8'h73, 1'b1, 0);
    total++;
    if (auth_l !== 2'b10) begin
      bad++; $display("FAIL resume_sp2 got=%b exp=10", auth_l);
    end
    for (int i = 0; i < 500 && auth_l !== 2'b00; i++) cycles(1);
    cycles(3);
    total++;
    if (off_cyc_l - sp_cyc_l !== 400) begin
      bad++;
      $display("FAIL timer_restart got=%0d exp=400", off_cyc_l - sp_cyc_l);
    end
    total++;
    if (tmo_cnt_l !== 1 || err_cnt_l !== 0) begin
      bad++;
      $display("FAIL resume_pulses tmo=%0d err=%0d exp=1/0",
               tmo_cnt_l, err_cnt_l);
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_byte(8'h67, 1'b0, 6);
    total++;
    if (err_cnt !== 1) begin
      bad++; $display("FAIL frame_err_pulse got=%0d exp=1", err_cnt);
    end
    total++;
    if (auth_state !== 2'b00) begin
      bad++; $display("FAIL frame_err_state got=%b exp=00", auth_state);
    end
    RX = 1'b0;
    cycles(200);
    total++;
    if (err_cnt !== 2) begin
      bad++; $display("FAIL break_one_err got=%0d exp=2", err_cnt);
    end
    RX = 1'b1;
    cycles(4);
    send_byte(8'h67, 1'b1, 4);
    total++;
    if (auth_state !== 2'b01 || err_cnt !== 2) begin
      bad++;
      $display("FAIL break_recover got=%b/%0d exp=01/2",
               auth_state, err_cnt);
    end
  endtask

  task automatic test_rst_midframe();
    RX = 1'b0;
    cycles(BD);
    RX = 1'b1;
    cycles(BD);
    RX = 1'b0;
    cycles(10);
    rst = 1'b1;
    #1;
    total++;
    if (auth_state !== 2'b00 || pwr_up !== 1'b0) begin
      bad++;
      $display("FAIL rst_midframe got=%b/%b exp=00/0", auth_state, pwr_up);
    end
    RX = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(3);
    send_byte(8'h67, 1'b1, 4);
    total++;
    if (auth_state !== 2'b01) begin
      bad++; $display("FAIL rst_then_go got=%b exp=01", auth_state);
    end
  endtask

  task automatic test_random();
    logic [1:0] exp;
    logic [7:0] b;
    int         exp_tmo;
    int         r;
    do_reset();
    exp = 2'b00;
    exp_tmo = 0;
    for (int n = 0; n < 14; n++) begin
      r = $urandom_range(0, 2);
      b = (r == 0) ? 8'h67 : (r == 1) ? 8'h73 : 8'($urandom);
      send_byte(b, 1'b1, $urandom_range(2, 12));
      exp = model(exp, b);
      total++;
      if (auth_state !== exp) begin
        bad++;
        $display("FAIL rand_%0d byte=%h got=%b exp=%b",
                 n, b, auth_state, exp);
      end
      if (exp == 2'b10) begin
        for (int i = 0; i < 200 && auth_state !== 2'b00; i++) cycles(1);
        exp = 2'b00;
        exp_tmo++;
        total++;
        if (auth_state !== exp) begin
          bad++; $display("FAIL rand_tmo_%0d got=%b exp=00", n, auth_state);
        end
      end
    end
    cycles(3);
    total++;
    if (tmo_cnt !== exp_tmo || err_cnt !== 0) begin
      bad++;
      $display("FAIL rand_pulses tmo=%0d/%0d err=%0d/0",
               tmo_cnt, exp_tmo, err_cnt);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    RX = 1'b1;
    rider_off = 1'b0;
    clr_cnt();
    rise_cyc = 0;
    sp_cyc = 0;
    off_cyc = 0;
    sp_cyc_l = 0;
    off_cyc_l = 0;
    frame_cyc = 0;
    test_reset();
    test_go_ignore();
    test_timeout();
    test_rider();
    test_resume();
    test_frame_err();
    test_rst_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
